// File: rtl/yiq_conv_arbiter.sv
// Round-robin front end that time-shares one pipelined RGB-to-YIQ converter among
// NUM_REQ requesters, tags each issue with its requester ID and queues results in a FIFO.
module yiq_conv_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [24*NUM_REQ-1:0]   req_rgb,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [7:0]              conv_r,
    output logic [7:0]              conv_g,
    output logic [7:0]              conv_b,
    input  logic [7:0]              conv_y,
    input  logic [7:0]              conv_i,
    input  logic [7:0]              conv_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic [7:0]              out_y,
    output logic [7:0]              out_i,
    output logic [7:0]              out_q,
    output logic [CNT_W-1:0]        inflight
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ID_W + 24;

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [7:0]       conv_r_q, conv_r_d;
    logic [7:0]       conv_g_q, conv_g_d;
    logic [7:0]       conv_b_q, conv_b_d;
    logic [LATENCY:0] tag_v_q, tag_v_d;
    logic [ID_W-1:0]  tag_id_q [LATENCY+1];
    logic [ID_W-1:0]  tag_id_d [LATENCY+1];
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];

    logic [CNT_W:0]   credit_used;
    logic             issue_ok;
    logic             found_hi, found_lo;
    logic [ID_W-1:0]  idx_hi, idx_lo, grant_idx;
    logic             any_valid;
    logic             issue;
    logic [23:0]      sel_rgb;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    // Credits cover both results still in the converter and entries already queued,
    // so a result that emerges always finds a free FIFO slot.
    assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    assign issue_ok    = (credit_used < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                if (ID_W'(k) >= ptr_q) begin
                    found_hi = 1'b1;
                    idx_hi   = ID_W'(k);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = ID_W'(k);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        any_valid = found_hi | found_lo;
        issue     = issue_ok & any_valid;
        req_ready = issue ? (NUM_REQ'(1) << grant_idx) : '0;
    end

    always_comb begin
        sel_rgb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_idx) begin
                sel_rgb = req_rgb[k*24 +: 24];
            end
        end
    end

    assign push      = tag_v_q[LATENCY];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;

    always_comb begin
        ptr_d    = ptr_q;
        conv_r_d = conv_r_q;
        conv_g_d = conv_g_q;
        conv_b_d = conv_b_q;
        if (issue) begin
            ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            conv_r_d = sel_rgb[23:16];
            conv_g_d = sel_rgb[15:8];
            conv_b_d = sel_rgb[7:0];
        end
    end

    always_comb begin
        tag_v_d     = {tag_v_q[LATENCY-1:0], issue};
        tag_id_d[0] = grant_idx;
        for (int s = 1; s <= LATENCY; s++) begin
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            conv_r_q   <= '0;
            conv_g_q   <= '0;
            conv_b_q   <= '0;
            tag_v_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            conv_r_q   <= conv_r_d;
            conv_g_q   <= conv_g_d;
            conv_b_q   <= conv_b_d;
            tag_v_q    <= tag_v_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int s = 0; s <= LATENCY; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem_q[wr_ptr_q] <= {tag_id_q[LATENCY], conv_y, conv_i, conv_q};
        end
    end

    assign head     = fifo_mem_q[rd_ptr_q];
    assign out_id   = out_valid ? head[ENT_W-1 -: ID_W] : '0;
    assign out_y    = out_valid ? head[23:16] : '0;
    assign out_i    = out_valid ? head[15:8]  : '0;
    assign out_q    = out_valid ? head[7:0]   : '0;
    assign conv_r   = conv_r_q;
    assign conv_g   = conv_g_q;
    assign conv_b   = conv_b_q;
    assign inflight = inflight_q;

endmodule

// File: tb/tb_yiq_conv_arbiter.sv
// Bench for yiq_conv_arbiter: a behavioural converter pipeline, directed requester
// patterns, and an expected-result queue checked whenever the FIFO head is accepted.
module tb_yiq_conv_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LATENCY    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = 2;
    localparam int CNT_W      = 4;
    localparam int ENT_W      = ID_W + 24;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [24*NUM_REQ-1:0] req_rgb;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            conv_r, conv_g, conv_b;
    logic [7:0]            conv_y, conv_i, conv_q;
    logic                  out_valid;
    logic                  out_ready;
    logic [ID_W-1:0]       out_id;
    logic [7:0]            out_y, out_i, out_q;
    logic [CNT_W-1:0]      inflight;

    yiq_conv_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rgb   (req_rgb),
        .req_ready (req_ready),
        .conv_r    (conv_r),
        .conv_g    (conv_g),
        .conv_b    (conv_b),
        .conv_y    (conv_y),
        .conv_i    (conv_i),
        .conv_q    (conv_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_y     (out_y),
        .out_i     (out_i),
        .out_q     (out_q),
        .inflight  (inflight)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- converter model (LATENCY register stages) ----------------
    function automatic logic [23:0] yiq_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int ri, gi, bi, y, i, q;
        ri = int'(r);
        gi = int'(g);
        bi = int'(b);
        y = (77 * ri + 150 * gi + 29 * bi) >>> 8;
        i = ((153 * ri - 70 * gi - 82 * bi) >>> 8) + 128;
        q = ((54 * ri - 134 * gi + 80 * bi) >>> 8) + 128;
        if (y > 255) y = 255;
        if (i > 255) i = 255;
        if (i < 0) i = 0;
        if (q > 255) q = 255;
        if (q < 0) q = 0;
        return {y[7:0], i[7:0], q[7:0]};
    endfunction

    logic [23:0] cv_stage [LATENCY];
    always @(posedge clk) begin
        cv_stage[0] <= yiq_of(conv_r, conv_g, conv_b);
        for (int s = 1; s < LATENCY; s++) cv_stage[s] <= cv_stage[s-1];
    end
    assign conv_y = cv_stage[LATENCY-1][23:16];
    assign conv_i = cv_stage[LATENCY-1][15:8];
    assign conv_q = cv_stage[LATENCY-1][7:0];

    // ---------------- hand-computed vectors ----------------
    logic [23:0] pix_rgb [6];
    logic [23:0] pix_yiq [6];
    int          req_pix [NUM_REQ];

    initial begin
        pix_rgb[0] = 24'hFFFFFF; pix_yiq[0] = {8'd255, 8'd128, 8'd128};
        pix_rgb[1] = 24'hFF0000; pix_yiq[1] = {8'd76,  8'd255, 8'd181};
        pix_rgb[2] = 24'h000000; pix_yiq[2] = {8'd0,   8'd128, 8'd128};
        pix_rgb[3] = 24'h00FF00; pix_yiq[3] = {8'd149, 8'd58,  8'd0};
        pix_rgb[4] = 24'h0000FF; pix_yiq[4] = {8'd28,  8'd46,  8'd207};
        pix_rgb[5] = 24'h808080; pix_yiq[5] = {8'd128, 8'd128, 8'd128};
    end

    // ---------------- scoreboard ----------------
    logic [ENT_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic             hold_v = 1'b0;
    logic [ENT_W-1:0] hold_head;
    logic [ENT_W-1:0] item;
    int               n_pop = 0;
    int               first_pop = -1;
    int               last_pop = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_valid) check("head_stable", {out_id, out_y, out_i, out_q}, hold_head);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_out: got id=%0d yiq=%0d/%0d/%0d, expected no output (cycle %0d)",
                             out_id, out_y, out_i, out_q, cyc);
                end else begin
                    item = exp_q.pop_front();
                    check("out_data", {out_id, out_y, out_i, out_q}, item);
                    n_pop++;
                    if (first_pop < 0) first_pop = cyc;
                    last_pop = cyc;
                end
            end
            check("outstanding_bound", exp_q.size() <= FIFO_DEPTH, 1);
            hold_v    = out_valid && !out_ready;
            hold_head = {out_id, out_y, out_i, out_q};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_reqs(input logic [NUM_REQ-1:0] mask);
        req_valid = mask;
        for (int k = 0; k < NUM_REQ; k++) req_rgb[k*24 +: 24] = pix_rgb[req_pix[k]];
    endtask

    // One cycle: check the grant, record the expected result, advance past the edge.
    task automatic step(input logic [NUM_REQ-1:0] exp_rdy);
        @(negedge clk);
        check("req_ready", req_ready, exp_rdy);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (exp_rdy[k]) exp_q.push_back({ID_W'(k), pix_yiq[req_pix[k]]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_head", {out_id, out_y, out_i, out_q}, 0);
        check("rst_inflight", inflight, 0);
        check("rst_conv", {conv_r, conv_g, conv_b}, 0);
        check("rst_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int pops0;
        bit found;
        rst_n = 1'b0;
        req_valid = '0;
        req_rgb = '0;
        out_ready = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) req_pix[k] = 2;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // 1: single white pixel from requester 2, latency and inflight
        out_ready = 1'b1;
        req_pix[2] = 0;
        set_reqs(4'b0100);
        step(4'b0100);
        set_reqs(4'b0000);
        lat = 0;
        found = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            @(negedge clk);
            if (n == 1) check("t1_inflight_busy", inflight, 1);
            if (out_valid) begin
                found = 1;
                lat = n;
            end
        end
        check("t1_latency", lat, LATENCY + 2);
        check("t1_inflight_idle", inflight, 0);
        @(posedge clk);
        #1;

        // 2: all requesters valid, grant order 0,1,2,3,... one per cycle
        do_reset();
        req_pix[0] = 1; req_pix[1] = 3; req_pix[2] = 4; req_pix[3] = 5;
        set_reqs(4'b1111);
        for (int i = 0; i < 12; i++) step(4'(1 << (i % 4)));
        set_reqs(4'b0000);
        wait_drain();

        // 3: downstream stalled: credits run out after FIFO_DEPTH issues
        out_ready = 1'b0;
        set_reqs(4'b1111);
        for (int i = 0; i < 8; i++) step(4'(1 << (i % 4)));
        for (int i = 0; i < 4; i++) step(4'b0000);
        @(negedge clk);
        check("t3_full_valid", out_valid, 1);
        check("t3_head_id", out_id, 0);
        check("t3_head_y", out_y, 76);
        check("t3_inflight", inflight, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        step(4'b0000);
        for (int i = 0; i < 4; i++) step(4'(1 << i));
        set_reqs(4'b0000);
        wait_drain();

        // 4: requester 1 streams red at full rate
        req_pix[1] = 1;
        first_pop = -1;
        pops0 = n_pop;
        set_reqs(4'b0010);
        for (int i = 0; i < 10; i++) step(4'b0010);
        set_reqs(4'b0000);
        wait_drain();
        check("t4_result_count", n_pop - pops0, 10);
        check("t4_back_to_back", last_pop - first_pop, 9);

        // 5: reset with three requests in flight
        req_pix[0] = 0;
        set_reqs(4'b0001);
        for (int i = 0; i < 3; i++) step(4'b0001);
        set_reqs(4'b0000);
        @(negedge clk);
        check("t5_inflight_pre", inflight, 3);
        do_reset();
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_no_stale", out_valid, 0);
        @(posedge clk);
        #1;
        req_pix[0] = 4; req_pix[1] = 3; req_pix[2] = 2; req_pix[3] = 5;
        set_reqs(4'b1111);
        step(4'b0001);
        set_reqs(4'b0000);
        wait_drain();

        // 6: requesters 1 and 3 with ptr at 2: 3 first, then wrap to 1
        req_pix[1] = 5; req_pix[3] = 3;
        set_reqs(4'b0010);
        step(4'b0010);
        set_reqs(4'b1010);
        step(4'b1000);
        step(4'b0010);
        step(4'b1000);
        step(4'b0010);
        set_reqs(4'b0000);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
